// File: rtl/reg_op_arbiter.sv
// Two-requester round-robin front end for a bank of NREG 16-bit
// E/FunSel registers. One command is latched at a time; its register's
// enable is held for N cycles (repeat count for inc/dec, one cycle for
// load/clear), then a Done pulse returns the arbiter to IDLE.

// Invariant monitor for the arbiter outputs; instantiated by the top.
module reg_op_arbiter_chk #(
  parameter int NREG = 4
) (
  input logic            Clock,
  input logic            Reset,
  input logic            AckA,
  input logic            AckB,
  input logic            DoneA,
  input logic            DoneB,
  input logic            Err,
  input logic            Busy,
  input logic [NREG-1:0] RegE
);

  a_ack_excl: assert property (@(posedge Clock) disable iff (Reset) !(AckA && AckB));
  a_done_excl: assert property (@(posedge Clock) disable iff (Reset) !(DoneA && DoneB));
  a_rege_onehot0: assert property (@(posedge Clock) disable iff (Reset) $onehot0(RegE));
  a_err_with_done: assert property (@(posedge Clock) disable iff (Reset) Err |-> (DoneA || DoneB));
  a_rege_only_busy: assert property (@(posedge Clock) disable iff (Reset) (RegE != '0) |-> Busy);

endmodule

module reg_op_arbiter #(
  parameter int NREG  = 4,
  parameter int SEL_W = 2,
  parameter int CNT_W = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             ReqA,
  input  logic [SEL_W-1:0] SelA,
  input  logic [1:0]       FunA,
  input  logic [15:0]      DataA,
  input  logic [CNT_W-1:0] CountA,
  input  logic             ReqB,
  input  logic [SEL_W-1:0] SelB,
  input  logic [1:0]       FunB,
  input  logic [15:0]      DataB,
  input  logic [CNT_W-1:0] CountB,
  output logic             AckA,
  output logic             AckB,
  output logic             DoneA,
  output logic             DoneB,
  output logic             Err,
  output logic             Busy,
  output logic [NREG-1:0]  RegE,
  output logic [1:0]       FunSel,
  output logic [15:0]      I
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_t;

  localparam logic [1:0] FUN_DEC   = 2'b00;
  localparam logic [1:0] FUN_INC   = 2'b01;
  localparam logic [1:0] FUN_LOAD  = 2'b10;
  localparam logic [1:0] FUN_CLEAR = 2'b11;

  // A select value outside the bank still runs its cycles, but with no enable.
  function automatic logic sel_in_range(input logic [SEL_W-1:0] sel);
    return (32'(sel) < 32'(NREG));
  endfunction

  // One-hot enable for the selected register; zero when out of range.
  function automatic logic [NREG-1:0] sel_decode(input logic [SEL_W-1:0] sel);
    logic [NREG-1:0] oh;
    oh = '0;
    for (int i = 0; i < NREG; i++) begin
      oh[i] = (32'(sel) == 32'(i));
    end
    return oh;
  endfunction

  // Number of enabled cycles: inc/dec repeat Count times (0 acts as 1),
  // load and clear always take exactly one cycle.
  function automatic logic [CNT_W-1:0] load_count(input logic [1:0]       fun,
                                                  input logic [CNT_W-1:0] count);
    logic [CNT_W-1:0] n;
    case (fun)
      FUN_DEC, FUN_INC: begin
        if (count == '0) begin
          n = CNT_W'(1);
        end else begin
          n = count;
        end
      end
      FUN_LOAD, FUN_CLEAR: n = CNT_W'(1);
      default:             n = CNT_W'(1);
    endcase
    return n;
  endfunction

  state_t           state_r;
  logic             prio_b_r;    // 1: B wins a tie (A was granted last)
  logic             owner_b_r;   // requester owning the running command
  logic             err_pend_r;  // running command targets a missing register
  logic [CNT_W-1:0] cnt_r;       // enabled cycles still to run, including this one

  logic             grant_a_s;
  logic             grant_b_s;
  logic [SEL_W-1:0] win_sel_s;
  logic [1:0]       win_fun_s;
  logic [15:0]      win_data_s;
  logic [CNT_W-1:0] win_count_s;

  // Round-robin arbitration between the two request lines.
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    if (ReqA && ReqB) begin
      if (prio_b_r) begin
        grant_b_s = 1'b1;
      end else begin
        grant_a_s = 1'b1;
      end
    end else if (ReqA) begin
      grant_a_s = 1'b1;
    end else if (ReqB) begin
      grant_b_s = 1'b1;
    end else begin
      grant_a_s = 1'b0;
      grant_b_s = 1'b0;
    end
  end

  // Steer the winning requester's command fields.
  always_comb begin
    win_sel_s   = SelA;
    win_fun_s   = FunA;
    win_data_s  = DataA;
    win_count_s = CountA;
    if (grant_b_s) begin
      win_sel_s   = SelB;
      win_fun_s   = FunB;
      win_data_s  = DataB;
      win_count_s = CountB;
    end else begin
      win_sel_s   = SelA;
      win_fun_s   = FunA;
      win_data_s  = DataA;
      win_count_s = CountA;
    end
  end

  // Command sequencer: accept in IDLE, hold the enable for N cycles in EXEC.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r    <= ST_IDLE;
      prio_b_r   <= 1'b0;
      owner_b_r  <= 1'b0;
      err_pend_r <= 1'b0;
      cnt_r      <= '0;
      AckA       <= 1'b0;
      AckB       <= 1'b0;
      DoneA      <= 1'b0;
      DoneB      <= 1'b0;
      Err        <= 1'b0;
      Busy       <= 1'b0;
      RegE       <= '0;
      FunSel     <= 2'b00;
      I          <= 16'h0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          DoneA <= 1'b0;
          DoneB <= 1'b0;
          Err   <= 1'b0;
          if (grant_a_s || grant_b_s) begin
            AckA       <= grant_a_s;
            AckB       <= grant_b_s;
            Busy       <= 1'b1;
            RegE       <= sel_decode(win_sel_s);
            FunSel     <= win_fun_s;
            I          <= win_data_s;
            cnt_r      <= load_count(win_fun_s, win_count_s);
            err_pend_r <= ~sel_in_range(win_sel_s);
            owner_b_r  <= grant_b_s;
            prio_b_r   <= grant_a_s;
            state_r    <= ST_EXEC;
          end else begin
            AckA <= 1'b0;
            AckB <= 1'b0;
            Busy <= 1'b0;
          end
        end
        ST_EXEC: begin
          AckA <= 1'b0;
          AckB <= 1'b0;
          if (cnt_r <= CNT_W'(1)) begin
            // Last enabled cycle ends here: release the bank and report.
            RegE    <= '0;
            Busy    <= 1'b0;
            DoneA   <= ~owner_b_r;
            DoneB   <= owner_b_r;
            Err     <= err_pend_r;
            cnt_r   <= '0;
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= '0;
          AckA    <= 1'b0;
          AckB    <= 1'b0;
          DoneA   <= 1'b0;
          DoneB   <= 1'b0;
          Err     <= 1'b0;
          Busy    <= 1'b0;
          RegE    <= '0;
        end
      endcase
    end
  end

  reg_op_arbiter_chk #(.NREG(NREG)) u_chk (
    .Clock (Clock),
    .Reset (Reset),
    .AckA  (AckA),
    .AckB  (AckB),
    .DoneA (DoneA),
    .DoneB (DoneB),
    .Err   (Err),
    .Busy  (Busy),
    .RegE  (RegE)
  );

endmodule

// File: doc/reg_op_arbiter.md
Name: reg_op_arbiter

Overview:
- Shares one bank of NREG 16-bit E/FunSel registers between two requesters, A and B (for example, the control unit and a test or loader port).
- Arbitrates round-robin and latches one command at a time.
- Sequences the selected register's E/FunSel/I lines, repeating an increment or decrement Count times.
- Sits between the requesters and the register bank. Its RegE, FunSel and I outputs drive the registers' E, FunSel and I inputs directly.

Parameters:
NREG, 4, number of registers in the bank (1..16)
SEL_W, 2, width of the register select field; must satisfy 2**SEL_W >= NREG
CNT_W, 4, width of the repeat count field

Ports:
Clock  in  1  system clock; all logic updates on posedge
Reset  in  1  synchronous, active-high reset
ReqA  in  1  requester A command valid; held until AckA is seen
SelA  in  SEL_W  target register index for A
FunA  in  2  operation for A: 00 dec, 01 inc, 10 load, 11 clear
DataA  in  16  load value for A
CountA  in  CNT_W  repeat count for A
ReqB, SelB, FunB, DataB, CountB  in  same as A  requester B command
AckA  out  1  one-cycle pulse: A's command accepted
AckB  out  1  one-cycle pulse: B's command accepted
DoneA  out  1  one-cycle pulse: A's command completed
DoneB  out  1  one-cycle pulse: B's command completed
Err  out  1  pulses together with Done when the command's Sel >= NREG
Busy  out  1  high while in EXEC
RegE  out  NREG  one-hot enable to the bank
FunSel  out  2  shared FunSel to the bank
I  out  16  shared load data to the bank

Behaviour:
- Reset values: all outputs are registered and reset to 0. State resets to IDLE, the priority pointer resets to A, and the internal counter resets to 0.
- Reset has priority over every other event. Reset asserted mid-EXEC aborts the command with no Done and no Err, and RegE reaches 0 on that same edge.
- States: IDLE and EXEC.
- IDLE, arbitration:
  - If exactly one Req is high, that requester wins.
  - If both are high, the requester not granted most recently wins; the pointer starts at A.
  - If neither is high, stay in IDLE.
- IDLE, on the edge that accepts the winner's command:
  - Ack of the winner goes to 1.
  - Sel/Fun/Data are latched; FunSel and I are loaded.
  - RegE gets bit Sel set, or all zeros if Sel >= NREG.
  - The counter loads N. N = Count for Fun 00/01 with Count==0 treated as 1; N = 1 for Fun 10/11.
  - The pointer updates to the winner, and state goes to EXEC.
- Consequently, the cycle after a request is sampled shows Ack=1, Busy=1 and the first enabled register cycle, all together.
- EXEC:
  - RegE, FunSel and I stay constant.
  - Ack is 0 after its single cycle.
  - The counter decrements each edge.
  - On the edge ending the N-th EXEC cycle, RegE goes to 0, the winner's Done goes to 1 (plus Err if Sel >= NREG), and state goes to IDLE.
  - Req inputs are ignored while in EXEC.
- Register effect: the target register sees exactly N enabled edges. Inc/dec wrap modulo 2^16 inside the register; the arbiter does not check for wrap.
- Done cycle: this is an IDLE cycle, and arbitration happens in it. Back-to-back commands therefore have exactly one idle cycle (RegE=0) between EXEC runs.
- Requester protocol:
  - The requester holds Req and its fields stable until it samples Ack=1.
  - It deasserts Req in the Ack cycle unless it has a new command, which is then eligible at the Done cycle.
  - Fields sampled outside the acceptance edge are don't-care.
- Invariants: Ack, Done and Err never pulse for both requesters in the same cycle. RegE is always one-hot or zero.

Test Plan:
- Reset, then ReqA with Sel=2, Fun=01, Count=3 -> next cycle AckA=1, Busy=1, RegE=0100, FunSel=01. RegE stays high for exactly 3 cycles; DoneA pulses in the 4th cycle; a reg2 model starting at 0 reads 3.
- ReqA and ReqB both high from reset -> A is granted first. B is granted in A's Done cycle (AckB in the following cycle), leaving exactly one cycle with RegE=0 between runs. With both held continuously, grants alternate A,B,A,B.
- ReqB with Fun=10, Data=16'hBEEF, Count=7 -> RegE high for exactly 1 cycle with I=BEEF; DoneB in the next cycle. Fun=11 also gives a single cycle.
- ReqA with Fun=00, Count=0 on a register holding 0 -> 1 enabled cycle; the register reads FFFF (wrap).
- NREG=3, ReqA with Sel=3 and Count=2 -> AckA, RegE=000 for 2 cycles, then DoneA=1 with Err=1.
- Reset asserted in the 2nd EXEC cycle of Count=5 -> on the next edge all outputs are 0 with no Done. A later ReqB and ReqA together grant A first (pointer reset).
